// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch with start/stop, lap freeze and clear buttons.
// Buttons are synchronised and edge-detected locally; a prescaler divides
// clk down to count ticks, and the live count can be frozen on data_out.
module bcd_stopwatch #(
    parameter int DIV = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] data_out,
    output logic        running,
    output logic        lap_hold,
    output logic        overflow,
    output logic        tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [2:0]    btnRaw;
    logic [2:0]    btnSync1;
    logic [2:0]    btnSync2;
    logic [2:0]    btnDelay;
    logic [2:0]    btnRise;
    logic          startEdge;
    logic          lapEdge;
    logic          clearEdge;
    logic          clearNow;
    logic [PW-1:0] prescaler;
    logic [15:0]   liveCount;
    logic [15:0]   holdCount;
    logic [15:0]   countInc;
    logic          countWrap;

    assign btnRaw    = {btn_clear, btn_lap, btn_start};
    assign btnRise   = btnSync2 & ~btnDelay;
    assign startEdge = btnRise[0];
    assign lapEdge   = btnRise[1];
    assign clearEdge = btnRise[2];

    // Clear only has an effect while the stopwatch is stopped.
    assign clearNow  = clearEdge & ~running;

    assign tick      = running && (prescaler == LAST);

    assign data_out  = lap_hold ? holdCount : liveCount;

    // Two-flop synchroniser plus a delay flop per button for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnSync1 <= 3'b000;
            btnSync2 <= 3'b000;
            btnDelay <= 3'b000;
        end else begin
            btnSync1 <= btnRaw;
            btnSync2 <= btnSync1;
            btnDelay <= btnSync2;
        end
    end

    // BCD increment of the live count; carry out of the top digit marks a wrap.
    always_comb begin
        logic carry;
        countInc = liveCount;
        carry    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (liveCount[i*4 +: 4] >= 4'd9) begin
                    countInc[i*4 +: 4] = 4'd0;
                end else begin
                    countInc[i*4 +: 4] = liveCount[i*4 +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        countWrap = carry;
    end

    // Run/stop toggles on every start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
        end else if (startEdge) begin
            running <= ~running;
        end
    end

    // Prescaler and live count advance only while running; prescaler holds when stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            liveCount <= 16'h0000;
            overflow  <= 1'b0;
        end else if (clearNow) begin
            prescaler <= '0;
            liveCount <= 16'h0000;
            overflow  <= 1'b0;
        end else if (running) begin
            if (prescaler == LAST) begin
                prescaler <= '0;
                liveCount <= countInc;
                if (countWrap) begin
                    overflow <= 1'b1;
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Lap edge alternates between capturing the pre-increment live count and releasing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_hold  <= 1'b0;
            holdCount <= 16'h0000;
        end else if (clearNow) begin
            lap_hold  <= 1'b0;
        end else if (lapEdge) begin
            if (!lap_hold) begin
                holdCount <= liveCount;
                lap_hold  <= 1'b1;
            end else begin
                lap_hold  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed self-checking bench for bcd_stopwatch with DIV=4.
module tb_bcd_stopwatch;

    logic        clk;
    logic        rst;
    logic        btn_start;
    logic        btn_lap;
    logic        btn_clear;
    logic [15:0] data_out;
    logic        running;
    logic        lap_hold;
    logic        overflow;
    logic        tick;

    int totalChecks  = 0;
    int badChecks    = 0;
    int edgeNum      = 0;
    int tickCount    = 0;
    int spacingErr   = 0;
    int prevTickEdge = -1;
    int base;
    int tickBase;
    int spacingBase;
    int pollCount;

    bcd_stopwatch #(.DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .btn_lap  (btn_lap),
        .btn_clear(btn_clear),
        .data_out (data_out),
        .running  (running),
        .lap_hold (lap_hold),
        .overflow (overflow),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so stimulus can be placed relative to a known edge.
    always @(posedge clk) edgeNum <= edgeNum + 1;

    // Count ticks mid-cycle and note any gap other than four edges.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            tickCount = tickCount + 1;
            if (prevTickEdge >= 0 && (edgeNum - prevTickEdge) != 4) spacingErr = spacingErr + 1;
            prevTickEdge = edgeNum;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        totalChecks = totalChecks + 1;
        if (observed !== expected) begin
            badChecks = badChecks + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic l, input logic c);
        btn_start = s;
        btn_lap   = l;
        btn_clear = c;
    endtask

    task automatic gotoEdge(input int target);
        while (edgeNum < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitValue(input logic [15:0] v, input int budget, input string tag);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            @(negedge clk);
            if (data_out === v) found = 1'b1;
            n++;
        end
        checkOutput(tag, data_out, v);
    endtask

    task automatic waitTick(input int budget, input string tag);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 16'(tick), 16'd1);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("rstData", data_out, 16'h0000);
        checkOutput("rstRun", 16'(running), 16'd0);
        checkOutput("rstLap", 16'(lap_hold), 16'd0);
        checkOutput("rstOvf", 16'(overflow), 16'd0);
        checkOutput("rstTick", 16'(tick), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        tickBase = tickCount;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("idleTicks", 16'(tickCount - tickBase), 16'd0);
        checkOutput("idleData", data_out, 16'h0000);
        checkOutput("idleRun", 16'(running), 16'd0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        pollCount = 0;
        while (running !== 1'b1 && pollCount < 10) begin
            @(posedge clk);
            #1;
            pollCount++;
        end
        checkOutput("runRise", 16'(running), 16'd1);
        checkOutput("runLatency", 16'(pollCount), 16'd3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tickBase    = tickCount;
        spacingBase = spacingErr;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("tickCount40", 16'(tickCount - tickBase), 16'd10);
        checkOutput("tickSpacing", 16'(spacingErr - spacingBase), 16'd0);
        checkOutput("data0010", data_out, 16'h0010);

        waitValue(16'h0099, 500, "reach0099");
        waitTick(8, "tickAt0099");
        @(posedge clk);
        #1;
        checkOutput("carry0100", data_out, 16'h0100);

        waitValue(16'h9999, 45000, "reach9999");
        checkOutput("ovfBeforeWrap", 16'(overflow), 16'd0);
        waitTick(8, "tickAt9999");
        @(posedge clk);
        #1;
        checkOutput("wrapData", data_out, 16'h0000);
        checkOutput("wrapOvf", 16'(overflow), 16'd1);
        checkOutput("wrapRun", 16'(running), 16'd1);

        waitValue(16'h0023, 200, "reach0023");
        base = edgeNum;
        applyStimulus(1'b0, 1'b1, 1'b0);
        gotoEdge(base + 3);
        checkOutput("lapCapture", data_out, 16'h0023);
        checkOutput("lapHoldSet", 16'(lap_hold), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 20);
        checkOutput("lapFrozen", data_out, 16'h0023);
        applyStimulus(1'b0, 1'b1, 1'b0);
        gotoEdge(base + 23);
        checkOutput("lapRelease", data_out, 16'h0028);
        checkOutput("lapHoldClr", 16'(lap_hold), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 25);
        applyStimulus(1'b0, 1'b1, 1'b0);
        gotoEdge(base + 28);
        checkOutput("lapOnTick", data_out, 16'h0029);
        checkOutput("lapOnTickHold", 16'(lap_hold), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 30);
        applyStimulus(1'b0, 1'b1, 1'b0);
        gotoEdge(base + 33);
        checkOutput("lapRelease2", data_out, 16'h0031);

        applyStimulus(1'b0, 1'b0, 1'b1);
        gotoEdge(base + 36);
        checkOutput("clearRunning", data_out, 16'h0032);
        checkOutput("clearRunningRun", 16'(running), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        gotoEdge(base + 39);
        checkOutput("stopRun", 16'(running), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 41);
        checkOutput("stoppedData", data_out, 16'h0032);
        checkOutput("stickyOvf", 16'(overflow), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        gotoEdge(base + 44);
        checkOutput("clearData", data_out, 16'h0000);
        checkOutput("clearOvf", 16'(overflow), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        gotoEdge(base + 46);
        applyStimulus(1'b1, 1'b0, 1'b0);
        gotoEdge(base + 49);
        checkOutput("restartRun", 16'(running), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 51);
        applyStimulus(1'b1, 1'b0, 1'b0);
        gotoEdge(base + 54);
        checkOutput("partialStop", 16'(running), 16'd0);
        checkOutput("partialData", data_out, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 56);
        applyStimulus(1'b1, 1'b0, 1'b0);
        gotoEdge(base + 59);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 61);
        checkOutput("resumeBefore", data_out, 16'h0001);
        checkOutput("resumeTick", 16'(tick), 16'd1);
        gotoEdge(base + 62);
        checkOutput("resumeAfter", data_out, 16'h0002);

        applyStimulus(1'b1, 1'b0, 1'b0);
        gotoEdge(base + 65);
        checkOutput("stop2Run", 16'(running), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 67);
        applyStimulus(1'b1, 1'b0, 1'b1);
        gotoEdge(base + 70);
        checkOutput("clrStartData", data_out, 16'h0000);
        checkOutput("clrStartRun", 16'(running), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoEdge(base + 73);
        checkOutput("clrStartNoTick", data_out, 16'h0000);
        checkOutput("clrStartTick", 16'(tick), 16'd1);
        gotoEdge(base + 74);
        checkOutput("clrStartFirst", data_out, 16'h0001);

        #3;
        rst = 1'b1;
        btn_start = 1'b1;
        #1;
        checkOutput("asyncRstData", data_out, 16'h0000);
        checkOutput("asyncRstRun", 16'(running), 16'd0);
        checkOutput("asyncRstTick", 16'(tick), 16'd0);
        checkOutput("asyncRstLap", 16'(lap_hold), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = edgeNum;
        gotoEdge(base + 2);
        checkOutput("heldStartEarly", 16'(running), 16'd0);
        gotoEdge(base + 3);
        checkOutput("heldStartRun", 16'(running), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
